led_pattern_seq: RTL and testbench
==================================

// Module: led_pattern_seq
// PURPOSE
//  Sits downstream of the board clock divider. It consumes a one-cycle tick strobe
//  and steps a pattern across the LED bank. A push button steps through four modes:
//  SHIFT, BOUNCE, COUNT and BLINK. The button input is synchronised and debounced
//  inside the block.
// PARAMETERS
//  LED_COUNT        6        number of LEDs driven; legal range 2..16
//  DEBOUNCE_CYCLES  270_000  consecutive stable clk cycles before a button change is accepted (10 ms @ 27 MHz); min 1
// PORTS
//  clk    in   1          system clock (27 MHz on board)
//  rst    in   1          asynchronous, active-high reset
//  tick   in   1          step strobe from the clock divider; sampled every clk; each high cycle = one step
//  btn    in   1          raw push button, active-high, asynchronous to clk
//  led    out  LED_COUNT  registered LED drive, bit0 = rightmost LED
//  mode   out  2          current mode: 0=SHIFT 1=BOUNCE 2=COUNT 3=BLINK
// BEHAVIOUR
//  Reset (asynchronous, active-high):
//   - mode=0, pattern=1, led=...0001, dir=up.
//   - Sync flops and debounced state cleared; the button is treated as released.
//   - Debounce counter = 0.
//  Button path:
//   - btn passes through a 2-flop synchroniser to give btn_s.
//   - When btn_s != stable, the counter increments; when btn_s == stable, the counter clears.
//   - When the counter reaches DEBOUNCE_CYCLES-1 while btn_s still differs, stable takes btn_s and the counter clears.
//   - A press is a stable 0->1 transition and produces a single-cycle internal pulse. Release has no effect.
//   - Latency: with btn held high from edge E0, mode changes at edge E0+DEBOUNCE_CYCLES+2.
//   - A glitch shorter than DEBOUNCE_CYCLES cycles is ignored.
//  Mode FSM:
//   - Each press advances 0->1->2->3->0 (wraps).
//   - On the edge where mode changes, the pattern loads the new mode's initial value and dir=up.
//   - A tick on that same cycle is dropped: press wins over tick.
//  Pattern step (on each clk edge with tick=1, no press):
//   - SHIFT (init 1): one-hot rotate left; bit LED_COUNT-1 wraps to bit0.
//   - BOUNCE (init 1, dir up): one-hot moves up to bit LED_COUNT-1, then reverses down to bit0, then reverses up.
//     End bits are lit for exactly one tick (6 LEDs: 1,2,4,8,16,32,16,8,4,2,1,2,...).
//   - COUNT (init 0): binary increment modulo 2^LED_COUNT; all-ones wraps to 0.
//   - BLINK (init 0): toggles between all-off and all-on.
//  Output timing:
//   - led is the pattern register: it changes on the same edge that samples tick=1. Zero extra latency.
//   - mode is a direct register output.
//   - tick held high for k cycles advances k steps. No edge detection is done on tick.
//  Reset mid-operation forces reset values immediately, regardless of tick, btn or the debounce state.
// CONFIGURATION
//  LED_ACTIVE_LOW_EN defined:
//   - led output = ~pattern, for boards whose LEDs sink current.
//   - Reset drive becomes ...1110. All other timing is unchanged.
//  LED_ACTIVE_LOW_EN undefined: led = pattern (active-high LEDs).
// TESTING (bench uses DEBOUNCE_CYCLES=4, LED_COUNT=6, macro undefined unless stated)
//  1. Reset, then 7 single-cycle ticks in SHIFT -> led = 02,04,08,10,20,01,02 (hex).
//  2. Two clean presses (btn high 10 cycles each), then 12 ticks
//     -> mode=2; led counts 01..0C. Preload 3F then tick -> 00.
//  3. One press, then 11 ticks in BOUNCE -> led = 02,04,08,10,20,10,08,04,02,01,02.
//  4. Btn high 3 cycles then low (glitch) -> mode stays 0.
//     Btn high from E0 -> mode=1 exactly at E0+6. Tick on that edge is ignored; led=01.
//  5. Assert rst mid-COUNT while tick=1 and btn bouncing -> same cycle: led=01, mode=0.
//     After release, the first press needs a full debounce.
//  6. Rebuild with LED_ACTIVE_LOW_EN and rerun scenario 1 -> led = 3E after reset, then 3D,3B,37,2F,1F,3E,3D.

Source files
------------

// File: rtl/led_pattern_seq.sv
// Tick-driven LED pattern sequencer with a debounced mode button (SHIFT/BOUNCE/COUNT/BLINK).
// Optional LED_ACTIVE_LOW_EN inverts the LED drive for current-sinking boards.
module led_pattern_seq #(
  parameter int LED_COUNT       = 6,
  parameter int DEBOUNCE_CYCLES = 270_000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 btn,
  output logic [LED_COUNT-1:0] led,
  output logic [1:0]           mode
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LED_COUNT-1:0] PAT_ONE = LED_COUNT'(1);

  typedef enum logic [1:0] {
    M_SHIFT  = 2'd0,
    M_BOUNCE = 2'd1,
    M_COUNT  = 2'd2,
    M_BLINK  = 2'd3
  } mode_t;

  function automatic logic [LED_COUNT-1:0] init_pattern(input mode_t m);
    case (m)
      M_SHIFT, M_BOUNCE: init_pattern = PAT_ONE;
      default:           init_pattern = '0;
    endcase
  endfunction

  function automatic logic [LED_COUNT-1:0] led_drive(input logic [LED_COUNT-1:0] p);
`ifdef LED_ACTIVE_LOW_EN
    led_drive = ~p;
`else
    led_drive = p;
`endif
  endfunction

  logic                 sync1_q, btn_s_q;
  logic                 stable_q, stable_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 press_q, press_d;
  mode_t                mode_q, mode_d;
  logic [LED_COUNT-1:0] pattern_q, pattern_d;
  logic                 dir_up_q, dir_up_d;
  logic [LED_COUNT-1:0] led_q, led_d;

  // Debounce: accept a change only after it has persisted DEBOUNCE_CYCLES cycles.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    press_d  = 1'b0;
    if (btn_s_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = btn_s_q;
        cnt_d    = '0;
        press_d  = btn_s_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Mode advance and pattern step; a press on the same cycle as a tick wins.
  always_comb begin
    mode_d    = mode_q;
    pattern_d = pattern_q;
    dir_up_d  = dir_up_q;
    if (press_q) begin
      mode_d    = mode_t'(mode_q + 2'd1);
      pattern_d = init_pattern(mode_d);
      dir_up_d  = 1'b1;
    end else if (tick) begin
      case (mode_q)
        M_SHIFT:  pattern_d = {pattern_q[LED_COUNT-2:0], pattern_q[LED_COUNT-1]};
        M_BOUNCE: begin
          if (dir_up_q) begin
            if (pattern_q[LED_COUNT-1]) begin
              pattern_d = pattern_q >> 1;
              dir_up_d  = 1'b0;
            end else begin
              pattern_d = pattern_q << 1;
            end
          end else begin
            if (pattern_q[0]) begin
              pattern_d = pattern_q << 1;
              dir_up_d  = 1'b1;
            end else begin
              pattern_d = pattern_q >> 1;
            end
          end
        end
        M_COUNT:  pattern_d = pattern_q + PAT_ONE;
        M_BLINK:  pattern_d = ~pattern_q;
        default:  pattern_d = pattern_q;
      endcase
    end else begin
      pattern_d = pattern_q;
    end
    led_d = led_drive(pattern_d);
  end

  // State registers; led_q mirrors pattern_d so the LEDs move on the tick edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      btn_s_q   <= 1'b0;
      stable_q  <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      mode_q    <= M_SHIFT;
      pattern_q <= PAT_ONE;
      dir_up_q  <= 1'b1;
      led_q     <= led_drive(PAT_ONE);
    end else begin
      sync1_q   <= btn;
      btn_s_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      mode_q    <= mode_d;
      pattern_q <= pattern_d;
      dir_up_q  <= dir_up_d;
      led_q     <= led_d;
    end
  end

  assign led  = led_q;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq (LED_COUNT=6, DEBOUNCE_CYCLES=4).
// Expected LED values follow LED_ACTIVE_LOW_EN when the bench is built with it.
module tb_led_pattern_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn = 1'b0;
  logic [5:0] led;
  logic [1:0] mode;

  int tests = 0;
  int fails = 0;

  logic [5:0] shift_seq  [7]  = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01, 6'h02};
  logic [5:0] bounce_seq [11] = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h10,
                                  6'h08, 6'h04, 6'h02, 6'h01, 6'h02};

  led_pattern_seq #(.LED_COUNT(6), .DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .btn (btn),
    .led (led),
    .mode(mode)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] exp_led(input logic [5:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clk1();
    clk1();
    rst = 1'b0;
  endtask

  task automatic press();
    btn = 1'b1;
    repeat (10) clk1();
    btn = 1'b0;
    repeat (10) clk1();
  endtask

  task automatic one_tick();
    tick = 1'b1;
    clk1();
    tick = 1'b0;
  endtask

  initial begin
    // Scenario 1: reset state and SHIFT rotation
    do_reset();
    chk("reset_led", led, exp_led(6'h01));
    chk("reset_mode", mode, 2'd0);
    for (int i = 0; i < 7; i++) begin
      one_tick();
      chk($sformatf("shift_%0d", i), led, exp_led(shift_seq[i]));
    end

    // Scenario 2: two presses into COUNT, count up, wrap from 3F
    press();
    chk("mode_after_press1", mode, 2'd1);
    chk("bounce_init", led, exp_led(6'h01));
    press();
    chk("mode_after_press2", mode, 2'd2);
    chk("count_init", led, exp_led(6'h00));
    for (int i = 1; i <= 12; i++) begin
      one_tick();
      chk($sformatf("count_%0d", i), led, exp_led(6'(i)));
    end
    tick = 1'b1;
    repeat (51) clk1();
    tick = 1'b0;
    chk("count_held_3f", led, exp_led(6'h3F));
    one_tick();
    chk("count_wrap", led, exp_led(6'h00));
    chk("count_mode", mode, 2'd2);

    // BLINK and wrap back to SHIFT
    press();
    chk("mode_blink", mode, 2'd3);
    chk("blink_init", led, exp_led(6'h00));
    one_tick();
    chk("blink_on", led, exp_led(6'h3F));
    one_tick();
    chk("blink_off", led, exp_led(6'h00));
    press();
    chk("mode_wrap", mode, 2'd0);
    chk("shift_reinit", led, exp_led(6'h01));

    // Scenario 3: BOUNCE sequence
    press();
    chk("mode_bounce", mode, 2'd1);
    for (int i = 0; i < 11; i++) begin
      one_tick();
      chk($sformatf("bounce_%0d", i), led, exp_led(bounce_seq[i]));
    end

    // Scenario 4: glitch rejection and exact press latency
    do_reset();
    btn = 1'b1;
    repeat (3) clk1();
    btn = 1'b0;
    repeat (10) clk1();
    chk("glitch_mode", mode, 2'd0);
    btn = 1'b1;
    repeat (6) clk1();
    chk("latency_e5_mode", mode, 2'd0);
    chk("latency_e5_led", led, exp_led(6'h01));
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    chk("latency_e6_mode", mode, 2'd1);
    chk("press_beats_tick", led, exp_led(6'h01));
    btn = 1'b0;
    repeat (10) clk1();

    // Scenario 5: asynchronous reset mid-COUNT
    press();
    chk("mode_count2", mode, 2'd2);
    one_tick();
    one_tick();
    one_tick();
    chk("count_pre_rst", led, exp_led(6'h03));
    tick = 1'b1;
    btn = 1'b1;
    #2;
    btn = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_led", led, exp_led(6'h01));
    chk("async_rst_mode", mode, 2'd0);
    btn = 1'b1;
    clk1();
    chk("rst_held_led", led, exp_led(6'h01));
    rst = 1'b0;
    tick = 1'b0;
    btn = 1'b0;
    repeat (3) clk1();
    btn = 1'b1;
    repeat (6) clk1();
    chk("post_rst_e5_mode", mode, 2'd0);
    clk1();
    chk("post_rst_e6_mode", mode, 2'd1);
    btn = 1'b0;
    repeat (10) clk1();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
